// File: rtl/glitc_scaler_readout_scheduler.sv
// Update/readout sequencer for the dual trigger scaler blocks: strobes the
// scaler latch, waits out the latch latency, then streams every scaler word.
module glitc_scaler_readout_scheduler #(
    parameter int NUM_PAIRS   = 4,
    parameter int PERIOD_W    = 28,
    parameter int LATCH_DELAY = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                force_i,
    input  logic                clear_i,
    output logic                update_o,
    output logic [7:0]          sel_o,
    input  logic [23:0]         scaler_i,
    output logic [31:0]         data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                busy_o,
    output logic                overflow_o
);

    localparam int NUM_WORDS = 2 * NUM_PAIRS;
    localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);
    localparam int WAIT_W = (LATCH_DELAY > 1) ? $clog2(LATCH_DELAY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((LATCH_DELAY > 0) ? (LATCH_DELAY - 1) : 0);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [PERIOD_W-1:0] PERIOD_ZERO = PERIOD_W'(0);
    localparam logic [PERIOD_W-1:0] PERIOD_ONE  = PERIOD_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_UPDATE  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_SELECT  = 3'd3,
        ST_PRESENT = 3'd4
    } state_t;

    state_t                state_r;
    logic [PERIOD_W-1:0]   period_cnt_r;
    logic [WAIT_W-1:0]     wait_cnt_r;
    logic [7:0]            idx_r;
    logic                  timer_fire_s;
    logic                  trigger_s;
    logic                  drop_s;

    // Trigger decode: timer and force merge into a single request.
    always_comb begin
        timer_fire_s = 1'b0;
        if ((period_cnt_r == PERIOD_ONE) && (period_i != PERIOD_ZERO)) begin
            timer_fire_s = 1'b1;
        end else begin
            timer_fire_s = 1'b0;
        end
        trigger_s = timer_fire_s | force_i;
        drop_s    = trigger_s & (state_r != ST_IDLE);
    end

    // Free-running period timer; a zero count picks up a newly enabled period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_cnt_r <= period_i;
        end else if (timer_fire_s || (period_cnt_r == PERIOD_ZERO)) begin
            period_cnt_r <= period_i;
        end else begin
            period_cnt_r <= period_cnt_r - PERIOD_ONE;
        end
    end

    // Sticky overrun flag; a drop in the same cycle beats the clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
        end else if (drop_s) begin
            overflow_o <= 1'b1;
        end else if (clear_i) begin
            overflow_o <= 1'b0;
        end else begin
            overflow_o <= overflow_o;
        end
    end

    // Readout sequencer with registered stream outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= WAIT_ZERO;
            idx_r      <= 8'd0;
            update_o   <= 1'b0;
            data_o     <= 32'd0;
            valid_o    <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            update_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (trigger_s) begin
                        state_r  <= ST_UPDATE;
                        update_o <= 1'b1;
                        busy_o   <= 1'b1;
                        idx_r    <= 8'd0;
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                ST_UPDATE: begin
                    idx_r      <= 8'd0;
                    wait_cnt_r <= WAIT_LOAD;
                    if (LATCH_DELAY == 0) begin
                        state_r <= ST_SELECT;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == WAIT_ZERO) begin
                        state_r <= ST_SELECT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - WAIT_ONE;
                    end
                end
                ST_SELECT: begin
                    data_o  <= {idx_r, scaler_i};
                    valid_o <= 1'b1;
                    state_r <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    // data_o and sel_o hold until the word is accepted.
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        if (idx_r == LAST_IDX) begin
                            state_r <= ST_IDLE;
                            busy_o  <= 1'b0;
                            idx_r   <= 8'd0;
                        end else begin
                            state_r <= ST_SELECT;
                            idx_r   <= idx_r + 8'd1;
                        end
                    end else begin
                        state_r <= ST_PRESENT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                    idx_r   <= 8'd0;
                end
            endcase
        end
    end

    assign sel_o = idx_r;

endmodule

// File: tb/tb_glitc_scaler_readout_scheduler.sv
// Directed bench for the scaler readout scheduler: a per-cycle vector table
// for the basic readout plus sequences for timer, overrun, backpressure and reset.
module tb_glitc_scaler_readout_scheduler;

    localparam int NUM_PAIRS   = 2;
    localparam int PERIOD_W    = 28;
    localparam int LATCH_DELAY = 4;

    logic                clk = 1'b0;
    logic                rst_i;
    logic [PERIOD_W-1:0] period_i;
    logic                force_i;
    logic                clear_i;
    logic                update_o;
    logic [7:0]          sel_o;
    logic [23:0]         scaler_i;
    logic [31:0]         data_o;
    logic                valid_o;
    logic                ready_i;
    logic                busy_o;
    logic                overflow_o;

    always #5 clk = ~clk;

    // Scaler mux model: word k reads 100*(k+1).
    assign scaler_i = 24'(100 * (int'(sel_o) + 1));

    glitc_scaler_readout_scheduler #(
        .NUM_PAIRS  (NUM_PAIRS),
        .PERIOD_W   (PERIOD_W),
        .LATCH_DELAY(LATCH_DELAY)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .period_i  (period_i),
        .force_i   (force_i),
        .clear_i   (clear_i),
        .update_o  (update_o),
        .sel_o     (sel_o),
        .scaler_i  (scaler_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .busy_o    (busy_o),
        .overflow_o(overflow_o)
    );

    typedef struct {
        logic        frc;
        logic        rdy;
        logic        upd;
        logic        vld;
        logic        bsy;
        logic        chk_sel;
        logic [7:0]  sel;
        logic        chk_dat;
        logic [31:0] dat;
    } vec_t;

    vec_t tbl [15];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(input logic f, input logic r, input logic u, input logic v,
                                input logic b, input logic cs, input logic [7:0] s,
                                input logic cd, input logic [31:0] d);
        vec_t x;
        x.frc = f; x.rdy = r; x.upd = u; x.vld = v; x.bsy = b;
        x.chk_sel = cs; x.sel = s; x.chk_dat = cd; x.dat = d;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [PERIOD_W-1:0] per);
        period_i = per;
        force_i  = 1'b0;
        clear_i  = 1'b0;
        ready_i  = 1'b1;
        rst_i    = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    task automatic wait_word(input logic [7:0] s, input string name);
        int k = 0;
        while (!(valid_o && sel_o == s) && k < 40) begin
            step();
            k++;
        end
        check(name, {31'd0, valid_o && (sel_o == s)}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy_o && k < 40) begin
            step();
            k++;
        end
        check(name, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int nupd;
        int nhs;
        int last_t;
        int first_ovf;
        int k;

        // Inputs during cycle i, expected outputs in cycle i+1 (force at cycle 0).
        tbl[0]  = mk(1, 1, 1, 0, 1, 0, 8'd0, 1, 32'h0000_0000);
        tbl[1]  = mk(0, 1, 0, 0, 1, 0, 8'd0, 1, 32'h0000_0000);
        tbl[2]  = mk(0, 1, 0, 0, 1, 0, 8'd0, 1, 32'h0000_0000);
        tbl[3]  = mk(0, 1, 0, 0, 1, 0, 8'd0, 1, 32'h0000_0000);
        tbl[4]  = mk(0, 1, 0, 0, 1, 0, 8'd0, 1, 32'h0000_0000);
        tbl[5]  = mk(0, 1, 0, 0, 1, 1, 8'd0, 1, 32'h0000_0000);
        tbl[6]  = mk(0, 1, 0, 1, 1, 1, 8'd0, 1, 32'h0000_0064);
        tbl[7]  = mk(0, 1, 0, 0, 1, 1, 8'd1, 0, 32'h0000_0000);
        tbl[8]  = mk(0, 1, 0, 1, 1, 1, 8'd1, 1, 32'h0100_00C8);
        tbl[9]  = mk(0, 1, 0, 0, 1, 1, 8'd2, 0, 32'h0000_0000);
        tbl[10] = mk(0, 1, 0, 1, 1, 1, 8'd2, 1, 32'h0200_012C);
        tbl[11] = mk(0, 1, 0, 0, 1, 1, 8'd3, 0, 32'h0000_0000);
        tbl[12] = mk(0, 1, 0, 1, 1, 1, 8'd3, 1, 32'h0300_0190);
        tbl[13] = mk(0, 1, 0, 0, 0, 0, 8'd0, 0, 32'h0000_0000);
        tbl[14] = mk(0, 1, 0, 0, 0, 0, 8'd0, 0, 32'h0000_0000);

        do_reset('0);
        check("reset update_o",   {31'd0, update_o},   32'd0);
        check("reset sel_o",      {24'd0, sel_o},      32'd0);
        check("reset data_o",     data_o,              32'd0);
        check("reset valid_o",    {31'd0, valid_o},    32'd0);
        check("reset busy_o",     {31'd0, busy_o},     32'd0);
        check("reset overflow_o", {31'd0, overflow_o}, 32'd0);

        // Basic readout, one vector per cycle.
        for (int i = 0; i < 15; i++) begin
            force_i = tbl[i].frc;
            ready_i = tbl[i].rdy;
            step();
            check($sformatf("basic[c%0d] update_o", i + 1), {31'd0, update_o}, {31'd0, tbl[i].upd});
            check($sformatf("basic[c%0d] valid_o", i + 1),  {31'd0, valid_o},  {31'd0, tbl[i].vld});
            check($sformatf("basic[c%0d] busy_o", i + 1),   {31'd0, busy_o},   {31'd0, tbl[i].bsy});
            check($sformatf("basic[c%0d] overflow_o", i + 1), {31'd0, overflow_o}, 32'd0);
            if (tbl[i].chk_sel) check($sformatf("basic[c%0d] sel_o", i + 1), {24'd0, sel_o}, {24'd0, tbl[i].sel});
            if (tbl[i].chk_dat) check($sformatf("basic[c%0d] data_o", i + 1), data_o, tbl[i].dat);
        end
        force_i = 1'b0;

        // Backpressure on word 1.
        do_reset('0);
        force_i = 1'b1;
        step();
        force_i = 1'b0;
        wait_word(8'd0, "bp word0 present");
        check("bp word0 data", data_o, 32'h0000_0064);
        step();
        ready_i = 1'b0;
        step();
        for (int j = 0; j < 5; j++) begin
            check($sformatf("bp hold%0d valid", j), {31'd0, valid_o}, 32'd1);
            check($sformatf("bp hold%0d data", j), data_o, 32'h0100_00C8);
            check($sformatf("bp hold%0d sel", j), {24'd0, sel_o}, 32'd1);
            step();
        end
        ready_i = 1'b1;
        check("bp rise valid", {31'd0, valid_o}, 32'd1);
        step();
        check("bp after hs valid", {31'd0, valid_o}, 32'd0);
        check("bp after hs sel", {24'd0, sel_o}, 32'd2);
        wait_idle("bp finish");

        // Timer only, period 50.
        do_reset(28'd50);
        nupd = 0; nhs = 0; last_t = -1;
        for (int t = 0; t < 170; t++) begin
            if (update_o) begin
                if (last_t < 0) check("timer first update t", t, 50);
                else check($sformatf("timer spacing #%0d", nupd), t - last_t, 50);
                last_t = t;
                nupd++;
            end
            if (valid_o && ready_i) nhs++;
            step();
        end
        check("timer update count", nupd, 3);
        check("timer handshakes", nhs, 12);
        check("timer overflow_o", {31'd0, overflow_o}, 32'd0);

        // Overrun, period 10: second fire at t=19 falls inside the readout.
        do_reset(28'd10);
        nupd = 0; first_ovf = -1;
        for (int t = 0; t < 26; t++) begin
            if (update_o) nupd++;
            if (overflow_o && first_ovf < 0) first_ovf = t;
            step();
        end
        check("overrun update count", nupd, 1);
        check("overrun overflow set t", first_ovf, 20);
        check("overrun overflow held", {31'd0, overflow_o}, 32'd1);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check("overrun cleared", {31'd0, overflow_o}, 32'd0);
        for (int t = 27; t < 39; t++) step();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check("overrun clear+drop same cycle", {31'd0, overflow_o}, 32'd1);

        // Force coincident with the timer fire at t=9.
        do_reset(28'd10);
        nupd = 0; last_t = -1;
        for (int t = 0; t < 16; t++) begin
            force_i = (t == 9);
            if (update_o) begin
                nupd++;
                last_t = t;
            end
            step();
        end
        force_i = 1'b0;
        check("simul update count", nupd, 1);
        check("simul update t", last_t, 10);
        check("simul overflow_o", {31'd0, overflow_o}, 32'd0);

        // Reset while word 2 is presented, then a clean restart.
        do_reset('0);
        force_i = 1'b1;
        step();
        force_i = 1'b0;
        wait_word(8'd0, "rst word0 present");
        force_i = 1'b1;
        step();
        force_i = 1'b0;
        wait_word(8'd2, "rst word2 present");
        check("rst pre overflow_o", {31'd0, overflow_o}, 32'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rst valid_o",    {31'd0, valid_o},    32'd0);
        check("rst busy_o",     {31'd0, busy_o},     32'd0);
        check("rst sel_o",      {24'd0, sel_o},      32'd0);
        check("rst update_o",   {31'd0, update_o},   32'd0);
        check("rst overflow_o", {31'd0, overflow_o}, 32'd0);
        force_i = 1'b1;
        step();
        force_i = 1'b0;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            if (valid_o && ready_i) begin
                check($sformatf("restart word%0d", k), data_o,
                      {8'(k), 24'(100 * (k + 1))});
                k++;
            end
            step();
        end
        check("restart word count", k, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
